mmio_host_bridge: RTL

//   Byte-stream to MMIO bridge sitting directly upstream of the SoC MMIO port.

---
 rtl/mmio_host_bridge.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mmio_host_bridge.sv
// Byte-stream to MMIO bridge: assembles host command packets into one req_* transaction
// and serializes the matching resp_* back as a 1+ADDR_W/8+DATA_W/8 byte response packet.
//
// state  | meaning
// S_CMD  | idle, waiting for a command byte
// S_ADDR | shifting in address bytes
// S_DATA | shifting in write-data bytes
// S_REQ  | presenting the request to the SoC
// S_WAIT | waiting for the SoC response
// S_TX   | streaming the response packet out
module mmio_host_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int RX_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_val,
  output logic              rx_rdy,
  output logic [7:0]        tx_byte,
  output logic              tx_val,
  input  logic              tx_rdy,
  output logic              req_cmd,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  output logic              req_val,
  input  logic              req_rdy,
  input  logic              resp_cmd,
  input  logic [ADDR_W-1:0] resp_addr,
  input  logic [DATA_W-1:0] resp_data,
  input  logic              resp_val,
  output logic              resp_rdy,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam int AB  = ADDR_W / 8;
  localparam int DB  = DATA_W / 8;
  localparam int TBY = 1 + AB + DB;
  localparam int TXW = 8 * TBY;
  localparam int BCW = $clog2(TBY + 1);
  localparam int TMW = $clog2(RX_TIMEOUT + 1);

  localparam logic [2:0] S_CMD  = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_REQ  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_TX   = 3'd5;

  localparam logic [TMW-1:0] TMR_LOAD = TMW'(RX_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TXW-1:0]    tx_sh_q, tx_sh_d;
  logic [BCW-1:0]    cnt_q, cnt_d;
  logic [TMW-1:0]    tmr_q, tmr_d;
  logic [7:0]        err_q, err_d;
  logic              rx_fire;
  logic              err_inc;

  assign rx_rdy   = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign rx_fire  = rx_val && rx_rdy;
  assign req_val  = (state_q == S_REQ);
  assign resp_rdy = (state_q == S_WAIT);
  assign tx_val   = (state_q == S_TX);
  assign busy     = (state_q != S_CMD);
  assign req_cmd  = cmd_q;
  assign req_addr = addr_q;
  assign req_data = data_q;
  assign tx_byte  = tx_sh_q[TXW-1 -: 8];
  assign err_cnt  = err_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tx_sh_d = tx_sh_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    err_inc = 1'b0;
    case (state_q)
      S_CMD: begin
        if (rx_fire) begin
          if (rx_byte == 8'h00 || rx_byte == 8'h01) begin
            cmd_d   = rx_byte[0];
            addr_d  = '0;
            data_d  = '0;
            cnt_d   = BCW'(AB - 1);
            tmr_d   = TMR_LOAD;
            state_d = S_ADDR;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      S_ADDR, S_DATA: begin
        // a byte arriving on the terminal-count cycle takes priority over the abort
        if (rx_fire) begin
          tmr_d = TMR_LOAD;
          cnt_d = cnt_q - BCW'(1);
          if (state_q == S_ADDR) addr_d = (addr_q << 8) | ADDR_W'(rx_byte);
          else                   data_d = (data_q << 8) | DATA_W'(rx_byte);
          if (cnt_q == '0) begin
            if (state_q == S_ADDR && cmd_q) begin
              cnt_d   = BCW'(DB - 1);
              state_d = S_DATA;
            end else begin
              state_d = S_REQ;
            end
          end
        end else if (tmr_q == '0) begin
          err_inc = 1'b1;
          addr_d  = '0;
          data_d  = '0;
          state_d = S_CMD;
        end else begin
          tmr_d = tmr_q - TMW'(1);
        end
      end
      S_REQ: begin
        if (req_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_val) begin
          // status byte is 0x40 with the echoed command in bit 0
          tx_sh_d = {8'h40 | {7'd0, resp_cmd}, resp_addr, resp_data};
          cnt_d   = BCW'(TBY - 1);
          state_d = S_TX;
        end
      end
      S_TX: begin
        if (tx_rdy) begin
          tx_sh_d = tx_sh_q << 8;
          cnt_d   = cnt_q - BCW'(1);
          if (cnt_q == '0) state_d = S_CMD;
        end
      end
      default: state_d = S_CMD;
    endcase
    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CMD;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      tx_sh_q <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tx_sh_q <= tx_sh_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

endmodule
